// File: rtl/core_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | core_pkg : ALU opcodes and fetch-stage state encoding           |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package core_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SHL  = 4'b0101;
   localparam logic [3:0] ALU_SHR  = 4'b0110;
   localparam logic [3:0] ALU_MOV  = 4'b0111;
   localparam logic [3:0] ALU_LT   = 4'b1000;
   localparam logic [3:0] ALU_EQL  = 4'b1001;
   localparam logic [3:0] ALU_RST  = 4'b1010;
   localparam logic [3:0] ALU_HALT = 4'b1011;
   localparam logic [3:0] ALU_LUT  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | sat_counter : up-counter with clear that sticks at all-ones     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
         count_q <= count_q + WIDTH'(1);
      end
   end

   assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_ctrl : PC sequencing, condition/carry flags, run FSM      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module fetch_ctrl
   import core_pkg::*;
#(
   parameter int              PC_W     = 10,
   parameter logic [PC_W-1:0] START_PC = '0,
   parameter int              CNT_W    = 16
) (
   input  logic             CLK,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             HaltEn,
   input  logic             BranchEn,
   input  logic             CondWrEn,
   input  logic             CarryWrEn,
   input  logic             CarryRst,
   input  logic [7:0]       AluOut,
   input  logic             AluZero,
   input  logic [1:0]       AluOvf,
   output logic [PC_W-1:0]  PC,
   output logic [1:0]       OverflowIn,
   output logic             CondFlag,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] InstCount
);

   fetch_state_t    state_q;
   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_d;
   logic [PC_W-1:0] br_off;
   logic [1:0]      ovf_q;
   logic            cond_q;
   logic            run_q;
   logic            done_q;
   logic            cnt_clr;
   logic            cnt_en;

   assign br_off = PC_W'($signed(AluOut));

   // Branch decision uses the flag as it stood before this edge.
   always_comb begin
      pc_d = pc_q + PC_W'(1);
      if (HaltEn) begin
         pc_d = pc_q;
      end else if (BranchEn && cond_q) begin
         pc_d = pc_q + br_off;
      end
   end

   always_ff @(posedge CLK) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         pc_q    <= START_PC;
         ovf_q   <= 2'b00;
         cond_q  <= 1'b0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, HALTED: begin
               if (Start) begin
                  state_q <= RUN;
                  pc_q    <= START_PC;
                  ovf_q   <= 2'b00;
                  cond_q  <= 1'b0;
                  run_q   <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            RUN: begin
               pc_q <= pc_d;
               if (CondWrEn) begin
                  cond_q <= ~AluZero;
               end
               if (CarryRst) begin
                  ovf_q <= 2'b00;
               end else if (CarryWrEn) begin
                  ovf_q <= AluOvf;
               end
               if (HaltEn) begin
                  state_q <= HALTED;
                  run_q   <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               run_q   <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cnt_clr = (state_q != RUN) && Start;
   assign cnt_en  = (state_q == RUN);

   sat_counter #(
      .WIDTH (CNT_W)
   ) u_inst_cnt (
      .clk_i   (CLK),
      .rst_ni  (Reset_n),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .count_o (InstCount)
   );

   assign PC         = pc_q;
   assign OverflowIn = ovf_q;
   assign CondFlag   = cond_q;
   assign Running    = run_q;
   assign Done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_fetch_ctrl : directed vector bench for fetch_ctrl            |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_fetch_ctrl;

   logic       CLK = 1'b0;
   logic       Reset_n, Start, HaltEn, BranchEn, CondWrEn, CarryWrEn, CarryRst, AluZero;
   logic [7:0] AluOut;
   logic [1:0] AluOvf;

   logic [9:0]  PC,  s_PC;
   logic [1:0]  OverflowIn, s_Ovf;
   logic        CondFlag, Running, Done, s_Cond, s_Run, s_Done;
   logic [15:0] InstCount;
   logic [3:0]  s_Cnt;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   fetch_ctrl u_dut (
      .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .HaltEn(HaltEn), .BranchEn(BranchEn),
      .CondWrEn(CondWrEn), .CarryWrEn(CarryWrEn), .CarryRst(CarryRst), .AluOut(AluOut),
      .AluZero(AluZero), .AluOvf(AluOvf), .PC(PC), .OverflowIn(OverflowIn),
      .CondFlag(CondFlag), .Running(Running), .Done(Done), .InstCount(InstCount)
   );

   // Narrow counter copy so saturation is reachable in a few cycles.
   fetch_ctrl #(.CNT_W(4)) u_sat (
      .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .HaltEn(HaltEn), .BranchEn(BranchEn),
      .CondWrEn(CondWrEn), .CarryWrEn(CarryWrEn), .CarryRst(CarryRst), .AluOut(AluOut),
      .AluZero(AluZero), .AluOvf(AluOvf), .PC(s_PC), .OverflowIn(s_Ovf),
      .CondFlag(s_Cond), .Running(s_Run), .Done(s_Done), .InstCount(s_Cnt)
   );

   typedef struct {
      logic       st, ha, br, cw, kw, kr;
      logic [7:0] out;
      logic       z;
      logic [1:0] ovf;
      int         e_pc;
      int         e_ovf;
      int         e_cond;
      int         e_run;
      int         e_done;
      int         e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, ha, br, cw, kw, kr, input logic [7:0] out,
                      input logic z, input logic [1:0] ovf,
                      input int pc, e_ovf, cond, run, done, cnt);
      vec_t v;
      v.st = st; v.ha = ha; v.br = br; v.cw = cw; v.kw = kw; v.kr = kr;
      v.out = out; v.z = z; v.ovf = ovf;
      v.e_pc = pc; v.e_ovf = e_ovf; v.e_cond = cond; v.e_run = run;
      v.e_done = done; v.e_cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %0d (0x%0h), expected %0d (0x%0h)", name, idx, act, act, exp, exp);
      end
   endtask

   task automatic drive(input logic st, ha, br, cw, kw, kr, input logic [7:0] out,
                        input logic z, input logic [1:0] ovf);
      Start = st; HaltEn = ha; BranchEn = br; CondWrEn = cw;
      CarryWrEn = kw; CarryRst = kr; AluOut = out; AluZero = z; AluOvf = ovf;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_all(input int idx, input int pc, e_ovf, cond, run, done, cnt);
      check("PC", idx, int'(PC), pc);
      check("OverflowIn", idx, int'(OverflowIn), e_ovf);
      check("CondFlag", idx, int'(CondFlag), cond);
      check("Running", idx, int'(Running), run);
      check("Done", idx, int'(Done), done);
      check("InstCount", idx, int'(InstCount), cnt);
   endtask

   initial begin
      Reset_n = 1'b0;
      drive(0,0,0,0,0,0,8'h00,0,2'b00);

      //  st ha br cw kw kr out    z  ovf     pc  ovf c r d cnt
      add(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    0, 0, 0,1,0, 0);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    1, 0, 0,1,0, 1);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    2, 0, 0,1,0, 2);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    3, 0, 0,1,0, 3);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    4, 0, 0,1,0, 4);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    5, 0, 0,1,0, 5);
      add(0, 1, 0, 0, 0, 0, 8'h00, 0, 2'b00,    5, 0, 0,0,1, 6);
      add(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    0, 0, 0,1,0, 0);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    1, 0, 0,1,0, 1);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    2, 0, 0,1,0, 2);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    3, 0, 0,1,0, 3);
      add(0, 0, 0, 1, 0, 0, 8'h00, 0, 2'b00,    4, 0, 1,1,0, 4);
      add(0, 0, 1, 0, 0, 0, 8'hFC, 0, 2'b00,    0, 0, 1,1,0, 5);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    1, 0, 1,1,0, 6);
      add(0, 0, 0, 1, 0, 0, 8'h00, 1, 2'b00,    2, 0, 0,1,0, 7);
      add(0, 0, 1, 0, 0, 0, 8'hFC, 0, 2'b00,    3, 0, 0,1,0, 8);
      add(0, 0, 1, 1, 0, 0, 8'hFC, 0, 2'b00,    4, 0, 1,1,0, 9);
      add(0, 0, 1, 0, 0, 0, 8'h02, 0, 2'b00,    6, 0, 1,1,0, 10);
      add(0, 0, 0, 0, 1, 0, 8'h00, 0, 2'b01,    7, 1, 1,1,0, 11);
      add(0, 0, 0, 0, 1, 1, 8'h00, 0, 2'b11,    8, 0, 1,1,0, 12);
      add(0, 0, 0, 0, 1, 0, 8'h00, 0, 2'b10,    9, 2, 1,1,0, 13);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,   10, 2, 1,1,0, 14);
      add(0, 1, 1, 0, 0, 0, 8'h05, 0, 2'b00,   10, 2, 1,0,1, 15);
      add(0, 1, 1, 1, 1, 1, 8'h05, 1, 2'b11,   10, 2, 1,0,1, 15);
      add(0, 1, 1, 1, 1, 1, 8'h05, 1, 2'b11,   10, 2, 1,0,1, 15);
      add(0, 1, 1, 1, 1, 1, 8'h05, 1, 2'b11,   10, 2, 1,0,1, 15);
      add(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    0, 0, 0,1,0, 0);
      add(1, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    1, 0, 0,1,0, 1);
      add(0, 0, 0, 1, 0, 0, 8'h00, 0, 2'b00,    2, 0, 1,1,0, 2);
      add(0, 0, 1, 0, 0, 0, 8'h80, 0, 2'b00,  898, 0, 1,1,0, 3);
      add(0, 0, 1, 0, 0, 0, 8'h7A, 0, 2'b00, 1020, 0, 1,1,0, 4);
      add(0, 0, 1, 0, 0, 0, 8'h05, 0, 2'b00,    1, 0, 1,1,0, 5);
      add(0, 0, 1, 0, 0, 0, 8'hFE, 0, 2'b00, 1023, 0, 1,1,0, 6);
      add(0, 0, 0, 0, 0, 0, 8'h00, 0, 2'b00,    0, 0, 1,1,0, 7);

      step();
      step();
      check_all(-1, 0, 0, 0, 0, 0, 0);
      Reset_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].st, vecs[i].ha, vecs[i].br, vecs[i].cw, vecs[i].kw, vecs[i].kr,
               vecs[i].out, vecs[i].z, vecs[i].ovf);
         step();
         check_all(i, vecs[i].e_pc, vecs[i].e_ovf, vecs[i].e_cond,
                   vecs[i].e_run, vecs[i].e_done, vecs[i].e_cnt);
      end

      // Saturation: narrow counter tops out at 15 while the wide one keeps going.
      drive(0,0,0,0,0,0,8'h00,0,2'b00);
      for (int n = 1; n <= 20; n++) begin
         step();
         if (n == 8 || n == 9 || n == 20) begin
            check("InstCount_wide", 100 + n, int'(InstCount), 7 + n);
            check("InstCount_sat", 100 + n, int'(s_Cnt), (7 + n > 15) ? 15 : 7 + n);
            check("PC_seq", 100 + n, int'(PC), n);
         end
      end

      // One-edge reset mid-run wins over Start and strobes.
      Reset_n = 1'b0;
      drive(1,0,1,1,1,0,8'h05,0,2'b11);
      step();
      check_all(200, 0, 0, 0, 0, 0, 0);
      check("InstCount_sat", 200, int'(s_Cnt), 0);

      // Idle ignores everything but Start.
      Reset_n = 1'b1;
      drive(0,1,1,1,1,0,8'h05,0,2'b11);
      step();
      step();
      check_all(201, 0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
